tx_skp_scheduler: RTL and testbench
===================================

TX_SKP_SCHEDULER -- requirements
Module: tx_skp_scheduler

Parameters (name, default, meaning)
- SKP_INTERVAL, 1180: PCLK cycles between SKP ordered-set requests; legal range 8..4095.
- SKP_COUNT, 3: number of SKP symbols following COM; legal range 1..5.

Interface
- REQ-001 SHALL provide these ports (name, direction, width, meaning):
  - PCLK, input, 1: symbol clock; all logic on its rising edge.
  - Rst, input, 1: asynchronous, active-high reset.
  - MAC_TX_Data, input, 8: MAC symbol.
  - MAC_TX_DataK, input, 1: MAC symbol is a K-code.
  - MAC_Data_En, input, 1: MAC symbol valid.
  - MAC_Ready, output, 1: scheduler accepts the MAC symbol this cycle.
  - TX_Symbol, output, 8: symbol to the 8b/10b encoder.
  - TX_SymbolK, output, 1: K flag for TX_Symbol.
  - TX_Valid, output, 1: TX_Symbol is valid.
  - Skp_Active, output, 1: high while COM or SKP is driven on TX_Symbol.
  - Skp_Overrun, output, 1: one-cycle pulse when a request is lost.
- REQ-002 SHALL contain exactly one clock domain (PCLK), with Rst asynchronous and active-high.

Function
- REQ-003 SHALL transfer a MAC symbol only in a cycle where MAC_Data_En=1 and MAC_Ready=1.
- REQ-004 SHALL implement a 12-bit interval counter:
  - increments every cycle;
  - wraps to 0 after SKP_INTERVAL-1;
  - sets skp_pending on wrap.
- REQ-005 SHALL pulse Skp_Overrun for one cycle if the counter wraps while skp_pending is already 1; the request count SHALL NOT accumulate beyond one.
- REQ-006 SHALL track in_packet:
  - set when an accepted symbol is K 0xFB (STP) or K 0x5C (SDP);
  - cleared when an accepted symbol is K 0xFD (END) or K 0xFE (EDB);
  - if set and clear conditions coincide, clear wins.
- REQ-007 SHALL implement the FSM states IDLE, DATA, SKP_COM and SKP_SYM:
  - IDLE/DATA -> SKP_COM when skp_pending=1 and in_packet=0 (evaluated on registered values);
  - otherwise IDLE -> DATA on an accepted symbol, and DATA -> IDLE on a cycle with no transfer;
  - SKP_COM -> SKP_SYM after one cycle;
  - SKP_SYM -> IDLE after SKP_COUNT cycles.
- REQ-008 SHALL drive MAC_Ready = 0 in SKP_COM and SKP_SYM, and in any cycle where skp_pending=1 and in_packet=0; otherwise MAC_Ready = 1 (combinational).
- REQ-009 SHALL clear skp_pending on the cycle the FSM enters SKP_COM. A wrap in that same cycle re-sets pending and SHALL NOT be reported as an overrun.
- REQ-010 SHALL register all outputs, with one cycle of latency from the accepted MAC symbol to TX_Symbol/TX_SymbolK with TX_Valid=1.
- REQ-011 SHALL output COM (0xBC, K=1) in SKP_COM, and SKP (0x1C, K=1) in each SKP_SYM cycle, with TX_Valid=1 and Skp_Active=1.
- REQ-012 SHALL output TX_Symbol=0x00, TX_SymbolK=0, TX_Valid=0 and Skp_Active=0 on cycles with neither a transfer nor an ordered set.
- REQ-013 SHALL never interleave COM/SKP inside a packet; the ordered-set sequence is contiguous (1 + SKP_COUNT cycles).

Reset
- REQ-014 SHALL, while Rst=1, immediately force:
  - TX_Symbol=0x00, TX_SymbolK=0, TX_Valid=0;
  - Skp_Active=0, Skp_Overrun=0, MAC_Ready=0;
  - counter=0, skp_pending=0, in_packet=0, state=IDLE.
- REQ-015 SHALL, on Rst assertion mid-SKP or mid-packet, abandon the sequence; after release, the first request occurs SKP_INTERVAL cycles after the first PCLK edge with Rst=0.
- REQ-016 SHALL assert MAC_Ready=1 in the first cycle after reset release (pending=0).

Verification (SKP_INTERVAL=16, SKP_COUNT=3 unless stated)
- REQ-017 Idle MAC (MAC_Data_En=0) -> every 16 cycles: BC/K, 1C/K, 1C/K, 1C/K with TX_Valid=1; MAC_Ready=0 from the wrap cycle through the last SKP cycle; Skp_Overrun never asserted.
- REQ-018 Continuous data with no packet framing -> each MAC symbol appears on TX_Symbol one cycle later; a 4-cycle COM+3xSKP gap is inserted every 16 cycles; no MAC symbol lost or duplicated (scoreboard).
- REQ-019 Packet STP, 30 data, END spanning a wrap -> MAC_Ready stays 1 until END is accepted; COM starts the cycle after the END output; the packet is unbroken.
- REQ-020 Packet held open (no END) for 40 cycles -> Skp_Overrun pulses at the 2nd wrap (cycle 32) and not at the 1st; exactly one COM+3xSKP follows END.
- REQ-021 Rst asserted during the 2nd SKP symbol -> outputs zero asynchronously; after release, the first COM appears 17 cycles later (wrap at 16, COM at 17); SKP_COUNT=1 run -> COM, SKP only.

Source files
------------

// File: rtl/tx_skp_scheduler.sv
// tx_skp_scheduler: inserts COM + SKP_COUNT x SKP ordered sets between
// packets every SKP_INTERVAL PCLK cycles on the MAC-to-encoder TX path.
// Ports:
//   PCLK, Rst (async, active-high)
//   MAC_TX_Data/MAC_TX_DataK/MAC_Data_En in, MAC_Ready out (handshake)
//   TX_Symbol/TX_SymbolK/TX_Valid out (registered, to 8b/10b encoder)
//   Skp_Active (ordered set on TX), Skp_Overrun (lost-request pulse)
module tx_skp_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       PCLK,
    input  logic       Rst,
    input  logic [7:0] MAC_TX_Data,
    input  logic       MAC_TX_DataK,
    input  logic       MAC_Data_En,
    output logic       MAC_Ready,
    output logic [7:0] TX_Symbol,
    output logic       TX_SymbolK,
    output logic       TX_Valid,
    output logic       Skp_Active,
    output logic       Skp_Overrun
);

    localparam logic [11:0] CNT_LAST = 12'(SKP_INTERVAL - 1);
    localparam logic [2:0]  SYM_LAST = 3'(SKP_COUNT - 1);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        SKP_COM,
        SKP_SYM
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  sym_q, sym_d;
    logic        pend_q, pend_d;
    logic        in_pkt_q, in_pkt_d;
    logic [7:0]  tx_sym_q, tx_sym_d;
    logic        tx_k_q, tx_k_d;
    logic        tx_vld_q, tx_vld_d;
    logic        act_q, act_d;
    logic        ovr_q, ovr_d;

    logic in_os;
    logic skp_due;
    logic xfer;
    logic wrap;
    logic enter_com;
    logic is_k;

    always_comb begin
        in_os     = (state_q == SKP_COM) || (state_q == SKP_SYM);
        // A request waits only while a packet is open.
        skp_due   = pend_q && !in_pkt_q;
        MAC_Ready = !Rst && !in_os && !skp_due;
        xfer      = MAC_Data_En && MAC_Ready;
        wrap      = (cnt_q == CNT_LAST);
        enter_com = !in_os && skp_due;
        is_k      = xfer && MAC_TX_DataK;

        cnt_d = wrap ? 12'd0 : cnt_q + 12'd1;

        // Entering COM consumes the request; a wrap in that same cycle
        // opens a fresh one instead of counting as lost.
        if (enter_com) begin
            pend_d = wrap;
        end else begin
            pend_d = pend_q || wrap;
        end
        ovr_d = wrap && pend_q && !enter_com;

        // Clear has priority over set.
        in_pkt_d = in_pkt_q;
        if (is_k && (MAC_TX_Data == K_STP || MAC_TX_Data == K_SDP)) begin
            in_pkt_d = 1'b1;
        end
        if (is_k && (MAC_TX_Data == K_END || MAC_TX_Data == K_EDB)) begin
            in_pkt_d = 1'b0;
        end

        state_d = state_q;
        sym_d   = sym_q;
        case (state_q)
            IDLE, DATA: begin
                if (enter_com) begin
                    state_d = SKP_COM;
                end else if (xfer) begin
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            SKP_COM: begin
                state_d = SKP_SYM;
                sym_d   = 3'd0;
            end
            SKP_SYM: begin
                if (sym_q == SYM_LAST) begin
                    state_d = IDLE;
                end else begin
                    sym_d = sym_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output registers are loaded from the next state so the symbol
        // on TX lines up with the registered state.
        tx_sym_d = 8'h00;
        tx_k_d   = 1'b0;
        tx_vld_d = 1'b0;
        act_d    = 1'b0;
        if (state_d == SKP_COM) begin
            tx_sym_d = K_COM;
            tx_k_d   = 1'b1;
            tx_vld_d = 1'b1;
            act_d    = 1'b1;
        end else if (state_d == SKP_SYM) begin
            tx_sym_d = K_SKP;
            tx_k_d   = 1'b1;
            tx_vld_d = 1'b1;
            act_d    = 1'b1;
        end else if (xfer) begin
            tx_sym_d = MAC_TX_Data;
            tx_k_d   = MAC_TX_DataK;
            tx_vld_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= 12'd0;
            sym_q    <= 3'd0;
            pend_q   <= 1'b0;
            in_pkt_q <= 1'b0;
            tx_sym_q <= 8'h00;
            tx_k_q   <= 1'b0;
            tx_vld_q <= 1'b0;
            act_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            pend_q   <= pend_d;
            in_pkt_q <= in_pkt_d;
            tx_sym_q <= tx_sym_d;
            tx_k_q   <= tx_k_d;
            tx_vld_q <= tx_vld_d;
            act_q    <= act_d;
            ovr_q    <= ovr_d;
        end
    end

    assign TX_Symbol   = tx_sym_q;
    assign TX_SymbolK  = tx_k_q;
    assign TX_Valid    = tx_vld_q;
    assign Skp_Active  = act_q;
    assign Skp_Overrun = ovr_q;

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// tb_tx_skp_scheduler: directed table-driven bench for tx_skp_scheduler
// (SKP_INTERVAL=16, SKP_COUNT=3 main instance; SKP_COUNT=1 second one).
module tb_tx_skp_scheduler;

    logic       PCLK;
    logic       Rst;
    logic [7:0] MAC_TX_Data;
    logic       MAC_TX_DataK;
    logic       MAC_Data_En;

    logic       MAC_Ready, TX_SymbolK, TX_Valid, Skp_Active, Skp_Overrun;
    logic [7:0] TX_Symbol;
    logic       MAC_Ready1, TX_SymbolK1, TX_Valid1, Skp_Active1, Skp_Overrun1;
    logic [7:0] TX_Symbol1;

    int n_chk  = 0;
    int n_pass = 0;

    tx_skp_scheduler #(.SKP_INTERVAL(16), .SKP_COUNT(3)) dut (
        .PCLK        (PCLK),
        .Rst         (Rst),
        .MAC_TX_Data (MAC_TX_Data),
        .MAC_TX_DataK(MAC_TX_DataK),
        .MAC_Data_En (MAC_Data_En),
        .MAC_Ready   (MAC_Ready),
        .TX_Symbol   (TX_Symbol),
        .TX_SymbolK  (TX_SymbolK),
        .TX_Valid    (TX_Valid),
        .Skp_Active  (Skp_Active),
        .Skp_Overrun (Skp_Overrun)
    );

    tx_skp_scheduler #(.SKP_INTERVAL(16), .SKP_COUNT(1)) dut1 (
        .PCLK        (PCLK),
        .Rst         (Rst),
        .MAC_TX_Data (MAC_TX_Data),
        .MAC_TX_DataK(MAC_TX_DataK),
        .MAC_Data_En (MAC_Data_En),
        .MAC_Ready   (MAC_Ready1),
        .TX_Symbol   (TX_Symbol1),
        .TX_SymbolK  (TX_SymbolK1),
        .TX_Valid    (TX_Valid1),
        .Skp_Active  (Skp_Active1),
        .Skp_Overrun (Skp_Overrun1)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       en;
        logic       k;
        logic [7:0] d;
        logic [7:0] e_sym;
        logic       e_k;
        logic       e_vld;
        logic       e_act;
        logic       e_rdy;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[64];

    function automatic logic [15:0] obs();
        return {3'b0, TX_Symbol, TX_SymbolK, TX_Valid,
                Skp_Active, MAC_Ready, Skp_Overrun};
    endfunction

    function automatic logic [15:0] obs1();
        return {3'b0, TX_Symbol1, TX_SymbolK1, TX_Valid1,
                Skp_Active1, MAC_Ready1, Skp_Overrun1};
    endfunction

    function automatic logic [15:0] mk(logic [7:0] s, logic k, logic v,
                                       logic a, logic r, logic o);
        return {3'b0, s, k, v, a, r, o};
    endfunction

    task automatic chk(string nm, int n, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, n, got, exp);
    endtask

    task automatic clr_tbl();
        for (int i = 0; i < 64; i++) begin
            tbl[i].en    = 1'b0;
            tbl[i].k     = 1'b0;
            tbl[i].d     = 8'h00;
            tbl[i].e_sym = 8'h00;
            tbl[i].e_k   = 1'b0;
            tbl[i].e_vld = 1'b0;
            tbl[i].e_act = 1'b0;
            tbl[i].e_rdy = 1'b1;
            tbl[i].e_ovr = 1'b0;
        end
    endtask

    // Symbol driven in cycle n appears on TX in cycle n+1.
    task automatic set_data(int n, logic k, logic [7:0] d);
        tbl[n].en      = 1'b1;
        tbl[n].k       = k;
        tbl[n].d       = d;
        tbl[n+1].e_sym = d;
        tbl[n+1].e_k   = k;
        tbl[n+1].e_vld = 1'b1;
    endtask

    // COM at n0, SKP at n0+1..n0+3, MAC_Ready low from n0-1.
    task automatic set_os(int n0);
        tbl[n0-1].e_rdy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tbl[n0+j].e_sym = (j == 0) ? 8'hBC : 8'h1C;
            tbl[n0+j].e_k   = 1'b1;
            tbl[n0+j].e_vld = 1'b1;
            tbl[n0+j].e_act = 1'b1;
            tbl[n0+j].e_rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        Rst          = 1'b1;
        MAC_Data_En  = 1'b0;
        MAC_TX_DataK = 1'b0;
        MAC_TX_Data  = 8'h00;
        #1;
        chk("rst_async", 0, obs(), 16'h0);
        @(negedge PCLK);
        chk("rst_hold", 0, obs(), 16'h0);
        chk("rst_hold1", 0, obs1(), 16'h0);
        Rst = 1'b0;
    endtask

    // Starts at the negedge of release; cycle n is after n posedges.
    task automatic run_table(string nm, int len);
        for (int n = 0; n < len; n++) begin
            MAC_Data_En  = tbl[n].en;
            MAC_TX_DataK = tbl[n].k;
            MAC_TX_Data  = tbl[n].d;
            #2;
            chk(nm, n, obs(), mk(tbl[n].e_sym, tbl[n].e_k, tbl[n].e_vld,
                                 tbl[n].e_act, tbl[n].e_rdy, tbl[n].e_ovr));
            @(negedge PCLK);
        end
        MAC_Data_En = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] nv;
        logic [7:0] ed;
        logic       rdy_exp;
        int         ncom;
        int         ndata;

        Rst          = 1'b0;
        MAC_Data_En  = 1'b0;
        MAC_TX_DataK = 1'b0;
        MAC_TX_Data  = 8'h00;

        // Idle MAC: ordered sets at 17 and 33.
        clr_tbl();
        set_os(17);
        set_os(33);
        do_reset();
        run_table("idle", 40);

        // Reset in the middle of the second SKP, then restart timing.
        do_reset();
        run_table("idle_pre", 19);
        #2;
        chk("skp2", 19, obs(), mk(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        #1 Rst = 1'b1;
        #1;
        chk("rst_mid_skp", 19, obs(), 16'h0);
        @(negedge PCLK);
        Rst = 1'b0;
        run_table("idle_post", 18);

        // STP, 30 data, END across wraps at 16 and 32.
        clr_tbl();
        set_data(0, 1'b1, 8'hFB);
        for (int i = 1; i <= 30; i++) set_data(i, 1'b0, 8'(i));
        set_data(31, 1'b1, 8'hFD);
        set_os(33);
        tbl[32].e_ovr = 1'b1;
        do_reset();
        run_table("pkt30", 40);

        // Packet held open 40 cycles: overrun only at 32.
        clr_tbl();
        set_data(0, 1'b1, 8'hFB);
        for (int i = 1; i <= 39; i++) set_data(i, 1'b0, 8'(i));
        set_data(40, 1'b1, 8'hFD);
        set_os(42);
        tbl[32].e_ovr = 1'b1;
        tbl[48].e_rdy = 1'b0;
        do_reset();
        run_table("pkt_long", 49);

        // SDP..EDB ending so COM entry coincides with a wrap.
        clr_tbl();
        set_data(0, 1'b1, 8'h5C);
        for (int i = 1; i <= 45; i++) set_data(i, 1'b0, 8'(i));
        set_data(46, 1'b1, 8'hFE);
        set_os(48);
        set_os(53);
        tbl[32].e_ovr = 1'b1;
        do_reset();
        run_table("wrap_at_com", 58);

        // Continuous raw data with a scoreboard.
        do_reset();
        nv    = 8'h00;
        ncom  = 0;
        ndata = 0;
        for (int n = 0; n <= 41; n++) begin
            MAC_Data_En  = (n < 41);
            MAC_TX_DataK = 1'b0;
            MAC_TX_Data  = nv;
            #2;
            rdy_exp = !((n >= 16 && n <= 20) || (n >= 32 && n <= 36));
            chk("b_ready", n, 16'(MAC_Ready), 16'(rdy_exp));
            if (TX_Valid && !Skp_Active) begin
                chk("b_have", n, 16'(q.size() > 0), 16'd1);
                if (q.size() > 0) begin
                    ed = q.pop_front();
                    ndata++;
                    chk("b_data", n, {7'b0, TX_SymbolK, TX_Symbol},
                        {8'b0, ed});
                end
            end else if (Skp_Active && TX_Symbol == 8'hBC) begin
                ncom++;
            end
            if (MAC_Ready && MAC_Data_En) begin
                q.push_back(nv);
                nv = nv + 8'd1;
            end
            @(negedge PCLK);
        end
        chk("b_left", 42, 16'(q.size()), 16'd0);
        chk("b_ndata", 42, 16'(ndata), 16'd31);
        chk("b_ncom", 42, 16'(ncom), 16'd2);

        // SKP_COUNT=1 instance: COM at 17, one SKP at 18.
        do_reset();
        for (int n = 0; n <= 20; n++) begin
            MAC_Data_En = 1'b0;
            #2;
            if (n == 17)
                chk("c1", n, obs1(), mk(8'hBC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
            else if (n == 18)
                chk("c1", n, obs1(), mk(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
            else
                chk("c1", n, obs1(), mk(8'h00, 1'b0, 1'b0, 1'b0,
                                        !(n == 16), 1'b0));
            @(negedge PCLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
